regfile_inex_recur: RTL and testbench

Parameter store holding the {i,z,k,l} recursion frames of the inexact-recursion accelerator. It feeds the parameter-fetch stage through a sequential-scan read port and a random read port. It also consumes the write-back stage's outputs through a sequential-append write port and a random-update write port. Valid entries are tracked by an occupancy counter, and the scan pointer wraps over the valid region.

---
 rtl/inex_recur_pkg.sv | 48 ++++
 rtl/inex_recur_ram.sv | 29 ++
 rtl/regfile_inex_recur.sv | 137 +++++++++++++
 tb/tb_regfile_inex_recur.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inex_recur_pkg.sv
// Shared definitions for the inexact-recursion parameter store:
// geometry, entry field layout and the data_o source selector.
package inex_recur_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 4096;

   localparam int I_LSB = 24;
   localparam int Z_LSB = 16;
   localparam int K_LSB = 8;
   localparam int L_LSB = 0;

   typedef struct packed {
      logic [7:0] i;
      logic [7:0] z;
      logic [7:0] k;
      logic [7:0] l;
   } entry_t;

   // Where the presented entry comes from after a read
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_BYP  = 2'd2
   } data_src_e;

   function automatic logic [DATA_W-1:0] pack_entry(input logic [7:0] i, input logic [7:0] z,
                                                    input logic [7:0] k, input logic [7:0] l);
      logic [DATA_W-1:0] w;
      w = '0;
      w[I_LSB +: 8] = i;
      w[Z_LSB +: 8] = z;
      w[K_LSB +: 8] = k;
      w[L_LSB +: 8] = l;
      return w;
   endfunction

   function automatic entry_t unpack_entry(input logic [DATA_W-1:0] w);
      entry_t e;
      e.i = w[I_LSB +: 8];
      e.z = w[Z_LSB +: 8];
      e.k = w[K_LSB +: 8];
      e.l = w[L_LSB +: 8];
      return e;
   endfunction

endpackage

// File: rtl/inex_recur_ram.sv
// Entry storage: one registered read port with enable, two write ports.
// No reset so the array maps onto block RAM.
module inex_recur_ram #(
   parameter int DATA_W = inex_recur_pkg::DATA_W,
   parameter int ADDR_W = inex_recur_pkg::ADDR_W,
   parameter int DEPTH  = inex_recur_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wa_en,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read returns the pre-write contents; the top handles write-first bypass
   always_ff @(posedge clk) begin
      if (wa_en) mem[wa_addr] <= wa_data;
      if (wb_en) mem[wb_addr] <= wb_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/regfile_inex_recur.sv
// Recursion-frame parameter store: scan and random read ports, append and
// update write ports, occupancy counter and sticky dropped-write flag.
module regfile_inex_recur #(
   parameter int DATA_W = inex_recur_pkg::DATA_W,
   parameter int ADDR_W = inex_recur_pkg::ADDR_W,
   parameter int DEPTH  = inex_recur_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              re_seq,
   input  logic              re_ran,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              seq_we,
   input  logic [DATA_W-1:0] seq_w_data,
   input  logic              ran_we,
   input  logic [ADDR_W-1:0] ran_w_addr,
   input  logic [DATA_W-1:0] ran_w_data,
   output logic [ADDR_W:0]   count_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              wrap_o,
   output logic              err_o
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0]   cnt;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] byp_q;
   logic [DATA_W-1:0] ram_q;
   logic              wrap_q;
   logic              err_q;
   inex_recur_pkg::data_src_e src_q;
   inex_recur_pkg::data_src_e src_nxt;

   logic              full;
   logic              empty;
   logic              seq_ok;
   logic              ran_ok;
   logic [ADDR_W:0]   ptr_inc;
   logic              seq_wrap;
   logic [ADDR_W-1:0] nxt;
   logic              seq_step;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              in_range;

   always_comb begin
      full     = (cnt == DEPTH_C);
      empty    = (cnt == '0);
      seq_ok   = seq_we & ~full;
      ran_ok   = ran_we & ({1'b0, ran_w_addr} < cnt);
      // Wrap bound is the count before this cycle's append
      ptr_inc  = {1'b0, rd_ptr} + 1'b1;
      seq_wrap = (ptr_inc == cnt);
      nxt      = seq_wrap ? '0 : ptr_inc[ADDR_W-1:0];
      seq_step = re_seq & ~re_ran & ~empty;
      rd_addr  = re_ran ? r_addr : nxt;
      rd_en    = (re_ran | seq_step) & ~clear;
      in_range = ({1'b0, rd_addr} < cnt);
      if (!in_range)
         src_nxt = inex_recur_pkg::SRC_ZERO;
      else if (ran_ok && (ran_w_addr == rd_addr))
         src_nxt = inex_recur_pkg::SRC_BYP;
      else
         src_nxt = inex_recur_pkg::SRC_RAM;
   end

   inex_recur_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_q),
      .wa_en   (seq_ok & ~clear),
      .wa_addr (cnt[ADDR_W-1:0]),
      .wa_data (seq_w_data),
      .wb_en   (ran_ok & ~clear),
      .wb_addr (ran_w_addr),
      .wb_data (ran_w_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rd_ptr <= '0;
         addr_q <= '0;
         byp_q  <= '0;
         src_q  <= inex_recur_pkg::SRC_ZERO;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (clear) begin
         cnt    <= '0;
         rd_ptr <= '0;
         addr_q <= '0;
         byp_q  <= '0;
         src_q  <= inex_recur_pkg::SRC_ZERO;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wrap_q <= seq_step & seq_wrap;
         if (rd_en) begin
            rd_ptr <= rd_addr;
            addr_q <= rd_addr;
            src_q  <= src_nxt;
            byp_q  <= ran_w_data;
         end
         if (seq_ok)
            cnt <= cnt + 1'b1;
         if ((seq_we && full) || (ran_we && !ran_ok))
            err_q <= 1'b1;
      end
   end

   always_comb begin
      case (src_q)
         inex_recur_pkg::SRC_RAM: data_o = ram_q;
         inex_recur_pkg::SRC_BYP: data_o = byp_q;
         default:                 data_o = '0;
      endcase
   end

   assign addr_o  = addr_q;
   assign count_o = cnt;
   assign empty_o = empty;
   assign full_o  = full;
   assign wrap_o  = wrap_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_regfile_inex_recur.sv
// Bench for regfile_inex_recur: directed steps followed by random traffic,
// all checked against an array-based behavioural model.
module tb_regfile_inex_recur;
   import inex_recur_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;
   localparam int DP = DEPTH;

   logic          clk;
   logic          rst_n;
   logic          clear;
   logic          re_seq;
   logic          re_ran;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] addr_o;
   logic [DW-1:0] data_o;
   logic          seq_we;
   logic [DW-1:0] seq_w_data;
   logic          ran_we;
   logic [AW-1:0] ran_w_addr;
   logic [DW-1:0] ran_w_data;
   logic [AW:0]   count_o;
   logic          empty_o;
   logic          full_o;
   logic          wrap_o;
   logic          err_o;

   regfile_inex_recur dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .re_seq     (re_seq),
      .re_ran     (re_ran),
      .r_addr     (r_addr),
      .addr_o     (addr_o),
      .data_o     (data_o),
      .seq_we     (seq_we),
      .seq_w_data (seq_w_data),
      .ran_we     (ran_we),
      .ran_w_addr (ran_w_addr),
      .ran_w_data (ran_w_data),
      .count_o    (count_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .wrap_o     (wrap_o),
      .err_o      (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [DW-1:0] m_mem [DP];
   int            m_count;
   int            m_ptr;
   int            m_addr;
   logic [DW-1:0] m_data;
   bit            m_wrap;
   bit            m_err;

   int vectors;
   int miscompares;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, ".addr"},  64'(addr_o),  64'(m_addr));
      check({ph, ".data"},  64'(data_o),  64'(m_data));
      check({ph, ".count"}, 64'(count_o), 64'(m_count));
      check({ph, ".empty"}, 64'(empty_o), 64'(m_count == 0));
      check({ph, ".full"},  64'(full_o),  64'(m_count == DP));
      check({ph, ".wrap"},  64'(wrap_o),  64'(m_wrap));
      check({ph, ".err"},   64'(err_o),   64'(m_err));
   endtask

   task automatic model_reset();
      m_count = 0;
      m_ptr   = 0;
      m_addr  = 0;
      m_data  = '0;
      m_wrap  = 0;
      m_err   = 0;
   endtask

   // One clock of behaviour computed from the current inputs and pre-edge state
   task automatic model_step();
      bit seq_ok;
      bit ran_ok;
      int n;
      if (clear) begin
         model_reset();
         return;
      end
      seq_ok = seq_we && (m_count < DP);
      ran_ok = ran_we && (int'(ran_w_addr) < m_count);
      m_wrap = 0;
      if (re_ran) begin
         m_ptr  = int'(r_addr);
         m_addr = int'(r_addr);
         if (int'(r_addr) < m_count)
            m_data = (ran_ok && ran_w_addr == r_addr) ? ran_w_data : m_mem[r_addr];
         else
            m_data = '0;
      end else if (re_seq && m_count > 0) begin
         n      = (m_ptr + 1) % m_count;
         m_wrap = (n == 0);
         m_ptr  = n;
         m_addr = n;
         m_data = (ran_ok && int'(ran_w_addr) == n) ? ran_w_data : m_mem[n];
      end
      if (seq_ok) begin
         m_mem[m_count] = seq_w_data;
         m_count++;
      end else if (seq_we) begin
         m_err = 1;
      end
      if (ran_ok) m_mem[ran_w_addr] = ran_w_data;
      else if (ran_we) m_err = 1;
   endtask

   task automatic idle();
      clear      = 0;
      re_seq     = 0;
      re_ran     = 0;
      r_addr     = '0;
      seq_we     = 0;
      seq_w_data = '0;
      ran_we     = 0;
      ran_w_addr = '0;
      ran_w_data = '0;
   endtask

   task automatic step(input string ph);
      model_step();
      @(posedge clk);
      #1;
      check_all(ph);
      idle();
   endtask

   task automatic append(input logic [DW-1:0] d);
      seq_we     = 1;
      seq_w_data = d;
      step("append");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // Reset asserted in the middle of traffic
      append(32'h0102_0304);
      append(32'h0506_0708);
      re_ran = 1; r_addr = 12'd1;
      step("pre_rst_read");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      check("async_rst.empty_const", 64'(empty_o), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      append(pack_entry(8'h01, 8'h02, 8'h03, 8'h04));
      append(32'h0506_0708);
      append(32'h090A_0B0C);
      re_ran = 1; r_addr = 12'd1;
      step("ran_read1");
      check("ran_read1.data_const", 64'(data_o), 64'h0506_0708);
      check("ran_read1.count_const", 64'(count_o), 64'd3);

      re_seq = 1;
      step("seq1");
      check("seq1.data_const", 64'(data_o), 64'h090A_0B0C);
      re_seq = 1;
      step("seq_wrap");
      check("seq_wrap.addr_const", 64'(addr_o), 64'd0);
      check("seq_wrap.wrap_const", 64'(wrap_o), 64'd1);
      step("wrap_drop");

      ran_we = 1; ran_w_addr = 12'd2; ran_w_data = 32'hAABB_CCDD;
      re_ran = 1; r_addr = 12'd2;
      step("bypass");
      check("bypass.data_const", 64'(data_o), 64'hAABB_CCDD);
      ran_we = 1; ran_w_addr = 12'd3; ran_w_data = 32'h1234_5678;
      step("upd_drop");
      step("err_sticky");
      check("err_sticky.const", 64'(err_o), 64'd1);

      seq_we = 1; seq_w_data = 32'h1111_1111;
      ran_we = 1; ran_w_addr = 12'd0; ran_w_data = 32'h2222_2222;
      step("dual_write");
      check("dual_write.count_const", 64'(count_o), 64'd4);
      re_ran = 1; r_addr = 12'd3;
      step("dual_rd3");
      check("dual_rd3.data_const", 64'(data_o), 64'h1111_1111);
      re_ran = 1; r_addr = 12'd0;
      step("dual_rd0");
      check("dual_rd0.data_const", 64'(data_o), 64'h2222_2222);
      re_ran = 1; r_addr = 12'd4;
      seq_we = 1; seq_w_data = 32'h3333_3333;
      step("append_addr_read");
      clear = 1; seq_we = 1; ran_we = 1; re_ran = 1; r_addr = 12'd1;
      step("clear");
      check("clear.count_const", 64'(count_o), 64'd0);
      check("clear.err_const", 64'(err_o), 64'd0);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         seq_we     = ($urandom_range(0, 1) == 1);
         seq_w_data = $urandom;
         ran_we     = ($urandom_range(0, 2) == 0);
         ran_w_addr = AW'($urandom_range(0, m_count + 2));
         ran_w_data = $urandom;
         re_ran     = ($urandom_range(0, 3) == 0);
         r_addr     = AW'($urandom_range(0, m_count + 2));
         re_seq     = (m_ptr < m_count) && ($urandom_range(0, 1) == 1);
         clear      = ($urandom_range(0, 99) == 0);
         step("rand");
      end

      // Fill to capacity
      clear = 1;
      step("fill_clear");
      while (m_count < DP) begin
         seq_we     = 1;
         seq_w_data = $urandom;
         re_seq     = ($urandom_range(0, 7) == 0);
         step("fill");
      end
      check("fill.full_const", 64'(full_o), 64'd1);
      check("fill.count_const", 64'(count_o), 64'd4096);
      seq_we = 1; seq_w_data = 32'hDEAD_BEEF;
      step("overflow");
      check("overflow.count_const", 64'(count_o), 64'd4096);
      check("overflow.err_const", 64'(err_o), 64'd1);
      re_ran = 1; r_addr = 12'd4095;
      step("last_read");
      re_seq = 1;
      step("full_wrap");
      check("full_wrap.wrap_const", 64'(wrap_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
